mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the fetch stage (IF) and the memory stage (MS) of the pipeline.
- Issues at most one memory access per cycle.
- Splits 32-bit MS accesses (PUSH/POP/LDD/STD of wide values) into two 16-bit beats.
- Routes returned read data to the owning requester.
- Drives the fetch stall.

Parameters:
ADDR_W, 20, memory word-address width
DATA_W, 16, memory word width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch requests a word
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch address accepted this cycle (combinational)
if_valid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  DATA_W  fetched word
stall_fetch  out  1  if_req & ~if_gnt
ms_req  in  1  memory-stage request; held with fields stable until ms_gnt
ms_we  in  1  1 = write, 0 = read
ms_wide  in  1  1 = two-word access
ms_addr  in  ADDR_W  base word address
ms_wdata  in  2*DATA_W  write data; low half to ms_addr, high half to ms_addr+1
ms_gnt  out  1  final beat issued this cycle (combinational)
ms_done  out  1  one-cycle pulse, cycle after ms_gnt
ms_rdata  out  2*DATA_W  read result, valid with ms_done
mem_addr  out  ADDR_W  memory address (combinational)
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous-read data for the address issued the previous cycle

Behaviour:
- Reset (synchronous, active-high), applied on the clock edge with reset=1:
  - state goes to IDLE; response tag goes to NONE.
  - if_valid=0, ms_done=0, ms_rdata=0, if_rdata=0, lo_reg=0.
  - While reset=1: if_gnt, ms_gnt and mem_we are forced to 0, and mem_addr=0.
- Reset mid-operation: a pending second beat is dropped. No ms_done or if_valid is produced for accesses issued before reset.
- FSM states: IDLE, MS_HI.
- IDLE arbitration (fixed priority MS > IF):
  - ms_req=1: issue beat 0.
    - mem_addr=ms_addr; mem_we=ms_we; mem_wdata=ms_wdata[DATA_W-1:0].
    - If ms_wide=1: ms_gnt=0 and go to MS_HI.
    - If ms_wide=0: ms_gnt=1 and stay in IDLE.
    - Tag = MS_LO.
  - Else if if_req=1: mem_addr=if_addr, mem_we=0, if_gnt=1, tag = IF.
  - Else: no access; mem_we=0, tag = NONE.
- MS_HI:
  - mem_addr=ms_addr+1, wrapping modulo 2^ADDR_W (all-ones address wraps to 0).
  - mem_we=ms_we; mem_wdata=ms_wdata[2*DATA_W-1:DATA_W].
  - ms_gnt=1; tag = MS_HI; next state IDLE.
  - IF is never granted in MS_HI; stall_fetch=1 if if_req.
- Response cycle (registered tag from the previous cycle):
  - IF: if_valid=1, if_rdata=mem_rdata.
  - MS_LO, narrow: ms_done=1; ms_rdata={0, mem_rdata} for reads.
  - MS_LO, wide: lo_reg<=mem_rdata; no done.
  - MS_HI: ms_done=1; ms_rdata={mem_rdata, lo_reg} for reads.
  - Writes also pulse ms_done; ms_rdata holds its previous value on writes.
  - if_rdata and ms_rdata hold their values when not updated.
- Latency:
  - Narrow access: ms_done 1 cycle after issue.
  - Wide access: ms_done 2 cycles after beat 0.
  - Fetch: if_valid 1 cycle after if_gnt.
- Throughput: back-to-back grants are allowed, so a fetch every cycle is possible. A new ms_req may be granted in the same cycle as ms_done.
- Simultaneous MS and IF requests: MS wins; IF stalls until a cycle in IDLE with ms_req=0.
- mem_wdata is don't-care when mem_we=0; drive 0.

Optional Feature:
ARB_RR_EN
- Defined:
  - IDLE arbitration is round-robin. A registered last_winner bit is set to MS on an MS beat-0 grant and to IF on an IF grant; it is reset to IF.
  - When both request, the requester that is not last_winner is served first.
  - MS_HI still completes atomically.
- Undefined: fixed MS > IF priority as above. last_winner does not exist.

Test Plan:
- Fetch only: if_req=1 at addresses 0x00010, 0x00011 on consecutive cycles, mem returns 0xA1A1, 0xB2B2 -> if_gnt=1 both cycles; if_valid in the following two cycles with if_rdata 0xA1A1, 0xB2B2; stall_fetch=0.
- Wide read at 0xFFFFF with mem[0xFFFFF]=0x1234, mem[0x00000]=0xABCD -> mem_addr 0xFFFFF then 0x00000; ms_gnt on 2nd cycle; ms_done on 3rd with ms_rdata=0xABCD1234.
- Wide write of 0xDEADBEEF to 0x00100 while if_req=1 -> mem_we=1 for two cycles writing 0xBEEF@0x00100 and 0xDEAD@0x00101; stall_fetch=1 for both; IF granted on 3rd cycle.
- Narrow read 0x00200 (mem=0x5555) concurrent with if_req -> MS granted first; ms_done next cycle with ms_rdata=0x00005555; IF granted in the cycle after ms_gnt once ms_req drops.
- Reset asserted in MS_HI cycle of a wide write -> mem_we=0 that cycle; no ms_done; next cycle IDLE with all outputs 0.
- ARB_RR_EN defined, ms_req and if_req held 1 for 4 cycles of narrow accesses -> grant order IF, MS, IF, MS.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the unified memory and mem_port_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // Fetch handshake: if_gnt accepts the address in the same cycle;
    // if_valid/if_rdata return the word one cycle later.
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_valid;
    logic [DATA_W-1:0]   if_rdata;
    logic                stall_fetch;

    // Memory-stage handshake: ms_req and its fields are held until ms_gnt
    // (final beat issued); ms_done pulses the cycle after ms_gnt.
    logic                ms_req;
    logic                ms_we;
    logic                ms_wide;
    logic [ADDR_W-1:0]   ms_addr;
    logic [2*DATA_W-1:0] ms_wdata;
    logic                ms_gnt;
    logic                ms_done;
    logic [2*DATA_W-1:0] ms_rdata;

    // Single-port memory with synchronous read.
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, ms_req, ms_we, ms_wide, ms_addr, ms_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, stall_fetch, ms_gnt, ms_done, ms_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, ms_req, ms_we, ms_wide, ms_addr, ms_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, stall_fetch, ms_gnt, ms_done, ms_rdata,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and memory stage; splits wide MS accesses into two beats.
// Optional macro ARB_RR_EN: round-robin IDLE arbitration instead of fixed MS > IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              dbg_state_o
);

    typedef enum logic {S_IDLE, S_MS_HI} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_MS_LO, TAG_MS_HI} tag_e;

    state_e              state_q, state_d;
    tag_e                tag_q, tag_d;
    logic                tag_we_q, tag_wide_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [2*DATA_W-1:0] ms_rdata_q;

    logic                pick_ms, pick_if;
    logic                ms_beat0, ms_beat1, if_issue;
    logic                if_valid, ms_done, ms_rd_upd;
    logic [2*DATA_W-1:0] ms_rdata_new;

`ifdef ARB_RR_EN
    logic                last_win_ms_q;
`endif

    always_comb begin
        pick_ms = 1'b0;
        pick_if = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef ARB_RR_EN
            pick_ms = bus.ms_req & (~bus.if_req | ~last_win_ms_q);
`else
            pick_ms = bus.ms_req;
`endif
            pick_if = bus.if_req & ~pick_ms;
        end
    end

    assign ms_beat0 = ~reset & pick_ms;
    assign ms_beat1 = ~reset & (state_q == S_MS_HI);
    assign if_issue = ~reset & pick_if;

    always_comb begin
        state_d = S_IDLE;
        if (ms_beat0 && bus.ms_wide) state_d = S_MS_HI;

        tag_d = TAG_NONE;
        if (ms_beat1)      tag_d = TAG_MS_HI;
        else if (ms_beat0) tag_d = TAG_MS_LO;
        else if (if_issue) tag_d = TAG_IF;
    end

    // Second beat addresses the next word; the adder wraps at the top of memory.
    always_comb begin
        bus.mem_addr = '0;
        if (ms_beat1)      bus.mem_addr = bus.ms_addr + ADDR_W'(1);
        else if (ms_beat0) bus.mem_addr = bus.ms_addr;
        else if (if_issue) bus.mem_addr = bus.if_addr;
    end

    assign bus.mem_we      = (ms_beat0 | ms_beat1) & bus.ms_we;
    assign bus.mem_wdata   = ~bus.mem_we ? '0 :
                             ms_beat1 ? bus.ms_wdata[2*DATA_W-1:DATA_W] : bus.ms_wdata[DATA_W-1:0];
    assign bus.if_gnt      = if_issue;
    assign bus.ms_gnt      = ms_beat1 | (ms_beat0 & ~bus.ms_wide);
    assign bus.stall_fetch = bus.if_req & ~if_issue;

    // Response side is decoded from last cycle's tag, aligned with mem_rdata.
    assign if_valid  = ~reset & (tag_q == TAG_IF);
    assign ms_done   = ~reset & ((tag_q == TAG_MS_HI) | ((tag_q == TAG_MS_LO) & ~tag_wide_q));
    assign ms_rd_upd = ms_done & ~tag_we_q;
    assign ms_rdata_new = (tag_q == TAG_MS_HI) ? {bus.mem_rdata, lo_q}
                                               : {{DATA_W{1'b0}}, bus.mem_rdata};

    assign bus.if_valid = if_valid;
    assign bus.if_rdata = if_valid ? bus.mem_rdata : if_rdata_q;
    assign bus.ms_done  = ms_done;
    assign bus.ms_rdata = ms_rd_upd ? ms_rdata_new : ms_rdata_q;
    assign dbg_state_o  = (state_q == S_MS_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q      <= TAG_NONE;
            tag_we_q   <= 1'b0;
            tag_wide_q <= 1'b0;
            lo_q       <= '0;
            if_rdata_q <= '0;
            ms_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_win_ms_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            if (ms_beat0) begin
                tag_we_q   <= bus.ms_we;
                tag_wide_q <= bus.ms_wide;
            end
            if ((tag_q == TAG_MS_LO) && tag_wide_q) lo_q <= bus.mem_rdata;
            if (if_valid)  if_rdata_q <= bus.mem_rdata;
            if (ms_rd_upd) ms_rdata_q <= ms_rdata_new;
`ifdef ARB_RR_EN
            if (ms_beat0)      last_win_ms_q <= 1'b1;
            else if (if_issue) last_win_ms_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
// Build with +define+ARB_RR_EN to exercise the round-robin arbitration section.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic dbg_state;

    mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(20), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem_m [logic [19:0]];
    always @(posedge clk) begin
        bus.mem_rdata <= mem_m.exists(bus.mem_addr) ? mem_m[bus.mem_addr] : 16'h0000;
        if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive a cycle's inputs after the falling edge; checks run 1 ns later.
    task automatic drive(input logic rst_v, input logic ifr, input logic [19:0] ifa,
                         input logic msr, input logic we, input logic wide,
                         input logic [19:0] msa, input logic [31:0] wd);
        @(negedge clk);
        reset        = rst_v;
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.ms_req   = msr;
        bus.ms_we    = we;
        bus.ms_wide  = wide;
        bus.ms_addr  = msa;
        bus.ms_wdata = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.ms_req = 1'b0; bus.ms_we = 1'b0;
        bus.ms_wide = 1'b0; bus.ms_addr = '0; bus.ms_wdata = '0;
        mem_m[20'h00010] = 16'hA1A1;
        mem_m[20'h00011] = 16'hB2B2;
        mem_m[20'hFFFFF] = 16'h1234;
        mem_m[20'h00000] = 16'hABCD;
        mem_m[20'h00200] = 16'h5555;

        // Reset forces grants and the memory port off even with requests present.
        drive(1'b1, 1'b1, 20'h00055, 1'b1, 1'b1, 1'b1, 20'h00066, 32'h12345678);
        check_eq("rst_if_gnt",   32'(bus.if_gnt), 32'h0);
        check_eq("rst_ms_gnt",   32'(bus.ms_gnt), 32'h0);
        check_eq("rst_mem_we",   32'(bus.mem_we), 32'h0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        drive(1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
        idle();
        check_eq("rst_if_valid", 32'(bus.if_valid), 32'h0);
        check_eq("rst_ms_done",  32'(bus.ms_done), 32'h0);
        check_eq("rst_ms_rdata", bus.ms_rdata, 32'h0);
        check_eq("rst_if_rdata", 32'(bus.if_rdata), 32'h0);
        check_eq("rst_state",    32'(dbg_state), 32'h0);

        // Back-to-back fetches.
        drive(1'b0, 1'b1, 20'h00010, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
        check_eq("f0_gnt",   32'(bus.if_gnt), 32'h1);
        check_eq("f0_stall", 32'(bus.stall_fetch), 32'h0);
        check_eq("f0_addr",  32'(bus.mem_addr), 32'h00010);
        check_eq("f0_valid", 32'(bus.if_valid), 32'h0);
        exp_q.push_back(16'hA1A1);
        drive(1'b0, 1'b1, 20'h00011, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
        check_eq("f1_gnt",   32'(bus.if_gnt), 32'h1);
        check_eq("f1_stall", 32'(bus.stall_fetch), 32'h0);
        check_eq("f1_addr",  32'(bus.mem_addr), 32'h00011);
        check_eq("f1_valid", 32'(bus.if_valid), 32'h1);
        if (bus.if_valid && exp_q.size() > 0) check_eq("f1_rdata", 32'(bus.if_rdata), 32'(exp_q.pop_front()));
        exp_q.push_back(16'hB2B2);
        idle();
        check_eq("f2_valid", 32'(bus.if_valid), 32'h1);
        if (bus.if_valid && exp_q.size() > 0) check_eq("f2_rdata", 32'(bus.if_rdata), 32'(exp_q.pop_front()));
        idle();
        check_eq("f3_valid", 32'(bus.if_valid), 32'h0);
        check_eq("f3_hold",  32'(bus.if_rdata), 32'h0000B2B2);
        check_eq("f_q_empty", 32'(exp_q.size()), 32'h0);

        // Wide read across the top of memory.
        drive(1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1, 20'hFFFFF, 32'h0);
        check_eq("wr0_addr", 32'(bus.mem_addr), 32'h000FFFFF);
        check_eq("wr0_gnt",  32'(bus.ms_gnt), 32'h0);
        check_eq("wr0_we",   32'(bus.mem_we), 32'h0);
        drive(1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1, 20'hFFFFF, 32'h0);
        check_eq("wr1_addr",  32'(bus.mem_addr), 32'h0);
        check_eq("wr1_gnt",   32'(bus.ms_gnt), 32'h1);
        check_eq("wr1_state", 32'(dbg_state), 32'h1);
        check_eq("wr1_done",  32'(bus.ms_done), 32'h0);
        idle();
        check_eq("wr2_done",  32'(bus.ms_done), 32'h1);
        check_eq("wr2_rdata", bus.ms_rdata, 32'hABCD1234);
        idle();
        check_eq("wr3_done",  32'(bus.ms_done), 32'h0);
        check_eq("wr3_hold",  bus.ms_rdata, 32'hABCD1234);

        // Wide write while fetch is waiting.
        drive(1'b0, 1'b1, 20'h00020, 1'b1, 1'b1, 1'b1, 20'h00100, 32'hDEADBEEF);
        check_eq("ww0_we",    32'(bus.mem_we), 32'h1);
        check_eq("ww0_addr",  32'(bus.mem_addr), 32'h00100);
        check_eq("ww0_wdata", 32'(bus.mem_wdata), 32'h0000BEEF);
        check_eq("ww0_stall", 32'(bus.stall_fetch), 32'h1);
        check_eq("ww0_ifgnt", 32'(bus.if_gnt), 32'h0);
        drive(1'b0, 1'b1, 20'h00020, 1'b1, 1'b1, 1'b1, 20'h00100, 32'hDEADBEEF);
        check_eq("ww1_we",    32'(bus.mem_we), 32'h1);
        check_eq("ww1_addr",  32'(bus.mem_addr), 32'h00101);
        check_eq("ww1_wdata", 32'(bus.mem_wdata), 32'h0000DEAD);
        check_eq("ww1_stall", 32'(bus.stall_fetch), 32'h1);
        check_eq("ww1_gnt",   32'(bus.ms_gnt), 32'h1);
        drive(1'b0, 1'b1, 20'h00020, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
        check_eq("ww2_ifgnt", 32'(bus.if_gnt), 32'h1);
        check_eq("ww2_done",  32'(bus.ms_done), 32'h1);
        check_eq("ww2_hold",  bus.ms_rdata, 32'hABCD1234);
        check_eq("ww2_wdata0", 32'(bus.mem_wdata), 32'h0);
        idle();
        check_eq("ww_mem_lo", 32'(mem_m[20'h00100]), 32'h0000BEEF);
        check_eq("ww_mem_hi", 32'(mem_m[20'h00101]), 32'h0000DEAD);

        // Narrow read beats a concurrent fetch.
        drive(1'b0, 1'b1, 20'h00030, 1'b1, 1'b0, 1'b0, 20'h00200, 32'h0);
        check_eq("nr0_msgnt", 32'(bus.ms_gnt), 32'h1);
        check_eq("nr0_ifgnt", 32'(bus.if_gnt), 32'h0);
        check_eq("nr0_stall", 32'(bus.stall_fetch), 32'h1);
        check_eq("nr0_addr",  32'(bus.mem_addr), 32'h00200);
        drive(1'b0, 1'b1, 20'h00030, 1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
        check_eq("nr1_done",  32'(bus.ms_done), 32'h1);
        check_eq("nr1_rdata", bus.ms_rdata, 32'h00005555);
        check_eq("nr1_ifgnt", 32'(bus.if_gnt), 32'h1);
        check_eq("nr1_addr",  32'(bus.mem_addr), 32'h00030);
        idle();

        // Reset during the second beat of a wide write.
        drive(1'b0, 1'b0, 20'h0, 1'b1, 1'b1, 1'b1, 20'h00300, 32'h11112222);
        check_eq("rw0_we",    32'(bus.mem_we), 32'h1);
        drive(1'b1, 1'b0, 20'h0, 1'b1, 1'b1, 1'b1, 20'h00300, 32'h11112222);
        check_eq("rw1_we",    32'(bus.mem_we), 32'h0);
        check_eq("rw1_addr",  32'(bus.mem_addr), 32'h0);
        check_eq("rw1_gnt",   32'(bus.ms_gnt), 32'h0);
        check_eq("rw1_done",  32'(bus.ms_done), 32'h0);
        idle();
        check_eq("rw2_state", 32'(dbg_state), 32'h0);
        check_eq("rw2_done",  32'(bus.ms_done), 32'h0);
        check_eq("rw2_valid", 32'(bus.if_valid), 32'h0);
        check_eq("rw2_ms_rd", bus.ms_rdata, 32'h0);
        check_eq("rw2_if_rd", 32'(bus.if_rdata), 32'h0);
        check_eq("rw2_we",    32'(bus.mem_we), 32'h0);
        check_eq("rw_no_hi",  32'(mem_m.exists(20'h00301)), 32'h0);

        // Both requesters held for four narrow accesses.
`ifdef ARB_RR_EN
        drive(1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b0, 20'h00200, 32'h0);
        check_eq("rr_pre_msgnt", 32'(bus.ms_gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 20'h00010, 1'b1, 1'b0, 1'b0, 20'h00200, 32'h0);
            check_eq($sformatf("rr%0d_ifgnt", i), 32'(bus.if_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            check_eq($sformatf("rr%0d_msgnt", i), 32'(bus.ms_gnt), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
`else
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 20'h00010, 1'b1, 1'b0, 1'b0, 20'h00200, 32'h0);
            check_eq($sformatf("fp%0d_ifgnt", i), 32'(bus.if_gnt), 32'h0);
            check_eq($sformatf("fp%0d_msgnt", i), 32'(bus.ms_gnt), 32'h1);
            check_eq($sformatf("fp%0d_stall", i), 32'(bus.stall_fetch), 32'h1);
        end
`endif
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
